// File: rtl/packet_source_if.sv
// Beat-level packet interface between the packet source and the packet controller.
// The master drives valid/eof/type/data; the slave returns ready.
interface packet_source_if #(
  parameter int DATA_W = 32
);
  logic              src_valid;
  logic              src_ready;
  logic              eof_flag;
  logic [1:0]        packet_type;
  logic [DATA_W-1:0] src_data;

  modport master (
    output src_valid,
    output eof_flag,
    output packet_type,
    output src_data,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  eof_flag,
    input  packet_type,
    input  src_data,
    output src_ready
  );
endinterface

// File: rtl/packet_source.sv
// Packet source: arbitrates data/ctrl/resp requesters and serialises the winner as len+1 beats.
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority resp > ctrl > data.
module packet_source #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_req_i,
  input  logic [LEN_W-1:0]  data_len_i,
  input  logic              ctrl_req_i,
  input  logic [LEN_W-1:0]  ctrl_len_i,
  input  logic              resp_req_i,
  input  logic [LEN_W-1:0]  resp_len_i,
  input  logic [DATA_W-1:0] beat_data_i,
  output logic [2:0]        grant_o,
  output logic              beat_pop_o,
  output logic              done_o,
  packet_source_if.master   src
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       type_q, type_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [2:0]       req;
  logic [2:0]       win;
  logic [1:0]       win_type;
  logic [LEN_W-1:0] win_len;
  logic             hs;
  logic             last_beat;

  assign req       = {resp_req_i, ctrl_req_i, data_req_i};
  assign last_beat = (cnt_q == len_q);
  assign hs        = src.src_valid & src.src_ready;

  assign src.src_valid   = (state_q == SEND);
  assign src.eof_flag    = src.src_valid & last_beat;
  assign src.packet_type = type_q;
  assign src.src_data    = beat_data_i;
  assign grant_o         = grant_q;
  assign beat_pop_o      = hs;
  assign done_o          = done_q;

`ifdef RR_ARB_EN
  logic [1:0] last_q, last_d;
  logic [1:0] idx;

  function automatic logic [1:0] rr_idx(input logic [1:0] last, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, last} + {1'b0, off};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Search order starts just after the most recently granted requester.
  always_comb begin
    win      = 3'b000;
    win_type = 2'd0;
    idx      = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      idx = rr_idx(last_q, 2'(i));
      if ((win == 3'b000) && req[idx]) begin
        win[idx] = 1'b1;
        win_type = idx;
      end
    end
  end
`else
  always_comb begin
    win      = 3'b000;
    win_type = 2'd0;
    if (req[2]) begin
      win      = 3'b100;
      win_type = 2'd2;
    end else if (req[1]) begin
      win      = 3'b010;
      win_type = 2'd1;
    end else if (req[0]) begin
      win      = 3'b001;
      win_type = 2'd0;
    end
  end
`endif

  always_comb begin
    case (win_type)
      2'd0:    win_len = data_len_i;
      2'd1:    win_len = ctrl_len_i;
      default: win_len = resp_len_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    type_d  = type_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef RR_ARB_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SEND;
          grant_d = win;
          type_d  = win_type;
          len_d   = win_len;
          cnt_d   = '0;
`ifdef RR_ARB_EN
          last_d  = win_type;
`endif
        end
      end
      SEND: begin
        if (hs) begin
          if (last_beat) begin
            state_d = IDLE;
            grant_d = 3'b000;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      type_q  <= 2'd0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef RR_ARB_EN
      // Pointer at resp so that data wins the first arbitration.
      last_q  <= 2'd2;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef RR_ARB_EN
      last_q  <= last_d;
`endif
    end
  end

  // Packet length is payload-like and is always reloaded before use.
  always_ff @(posedge clk) begin
    len_q <= len_d;
  end

endmodule

// File: tb/tb_packet_source.sv
// Directed bench for packet_source: a packet-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_packet_source;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              data_req = 1'b0, ctrl_req = 1'b0, resp_req = 1'b0;
  logic [LEN_W-1:0]  data_len = '0, ctrl_len = '0, resp_len = '0;
  logic [DATA_W-1:0] beat_data = 32'hA000_0000;
  logic [2:0]        grant;
  logic              beat_pop, done;

  packet_source_if #(.DATA_W(DATA_W)) sif ();

  packet_source #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req), .data_len_i(data_len),
    .ctrl_req_i(ctrl_req), .ctrl_len_i(ctrl_len),
    .resp_req_i(resp_req), .resp_len_i(resp_len),
    .beat_data_i(beat_data),
    .grant_o(grant), .beat_pop_o(beat_pop), .done_o(done),
    .src(sif.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Reference model: one packet in flight, tracked as type/length/beats sent.
  logic       m_busy = 1'b0, m_done = 1'b0, started = 1'b0;
  logic [1:0] m_type = 2'd0;
  int         m_len = 0, m_sent = 0, m_last = 2, m_pick, m_pick_len;

  function automatic int pick(input logic [2:0] r, input int last);
`ifdef RR_ARB_EN
    for (int i = 1; i <= 3; i++)
      if (r[(last + i) % 3]) return (last + i) % 3;
    return -1;
`else
    if (r[2]) return 2;
    if (r[1]) return 1;
    if (r[0]) return 0;
    return -1;
`endif
  endfunction

  always_comb begin
    m_pick = pick({resp_req, ctrl_req, data_req}, m_last);
    m_pick_len = (m_pick == 0) ? int'(data_len) : (m_pick == 1) ? int'(ctrl_len) : int'(resp_len);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_type <= 2'd0; m_sent <= 0; m_last <= 2; started <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (sif.src_ready) begin
          if (m_sent == m_len) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end else begin
            m_sent <= m_sent + 1;
          end
        end
      end else if (m_pick >= 0) begin
        m_busy <= 1'b1; m_type <= 2'(m_pick); m_len <= m_pick_len; m_sent <= 0; m_last <= m_pick;
      end
    end
  end

  // Requester behaviour: present the next beat after each accepted one.
  always @(posedge clk) begin
    if (sif.src_valid && sif.src_ready) beat_data <= beat_data + 1;
  end

  logic [8:0] got_vec, exp_vec;
  assign got_vec = {sif.src_valid, sif.eof_flag, sif.packet_type, grant, beat_pop, done};
  assign exp_vec = {m_busy, m_busy && (m_sent == m_len), m_type,
                    m_busy ? (3'b001 << m_type) : 3'b000, m_busy && sif.src_ready, m_done};

  always @(negedge clk) begin
    if (started) begin
      check("cycle_outputs", 32'(got_vec), 32'(exp_vec));
      check("src_data", sif.src_data, beat_data);
    end
  end

  // Packet log reconstructed from the DUT's interface activity.
  int log_type[$];
  int log_beats[$];
  int cur_beats = 0, pop_total = 0, done_total = 0;

  always @(negedge clk) begin
    if (rst) begin
      cur_beats <= 0;
    end else begin
      if (beat_pop) begin
        pop_total <= pop_total + 1;
        if (sif.eof_flag) begin
          log_type.push_back(int'(sif.packet_type));
          log_beats.push_back(cur_beats + 1);
          cur_beats <= 0;
        end else begin
          cur_beats <= cur_beats + 1;
        end
      end
      if (done) done_total <= done_total + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_pkt(input string name, input int idx, input int typ, input int beats);
    if (idx < log_type.size()) begin
      check({name, "_type"}, 32'(log_type[idx]), 32'(typ));
      check({name, "_beats"}, 32'(log_beats[idx]), 32'(beats));
    end else begin
      check({name, "_present"}, 32'(log_type.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int base, p0, d0;
    bit pat[7];
    sif.src_ready = 1'b0;
    step();
    step();
    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(sif.src_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_type", 32'(sif.packet_type), 32'd0);
    rst = 1'b0;
    step();

    // T1: single-beat data packet
    data_req = 1'b1; data_len = 4'd0; sif.src_ready = 1'b1;
    step();
    data_req = 1'b0;
    @(negedge clk);
    check("t1_valid", 32'(sif.src_valid), 32'd1);
    check("t1_eof", 32'(sif.eof_flag), 32'd1);
    check("t1_type", 32'(sif.packet_type), 32'd0);
    check("t1_grant", 32'(grant), 32'b001);
    step();
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_gap_valid", 32'(sif.src_valid), 32'd0);
    step();

    // T2: 4-beat ctrl packet with stalls
    sif.src_ready = 1'b0; ctrl_req = 1'b1; ctrl_len = 4'd3;
    base = log_type.size();
    step();
    ctrl_req = 1'b0;
    p0 = pop_total;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      sif.src_ready = pat[i];
      step();
    end
    sif.src_ready = 1'b0;
    check("t2_pops", 32'(pop_total - p0), 32'd4);
    check_pkt("t2_pkt", base, 1, 4);
    step();

    // T3: all requesters pending for three packets
    do_reset();
    data_req = 1'b1; ctrl_req = 1'b1; resp_req = 1'b1;
    data_len = 4'd1; ctrl_len = 4'd1; resp_len = 4'd1; sif.src_ready = 1'b1;
    base = log_type.size();
    repeat (7) step();
    data_req = 1'b0; ctrl_req = 1'b0; resp_req = 1'b0;
    repeat (4) step();
    check("t3_count", 32'(log_type.size() - base), 32'd3);
`ifdef RR_ARB_EN
    check_pkt("t3_p0", base, 0, 2);
    check_pkt("t3_p1", base + 1, 1, 2);
    check_pkt("t3_p2", base + 2, 2, 2);
`else
    check_pkt("t3_p0", base, 2, 2);
    check_pkt("t3_p1", base + 1, 2, 2);
    check_pkt("t3_p2", base + 2, 2, 2);
`endif

    // T4: reset during the third beat of an 8-beat resp packet
    resp_req = 1'b1; resp_len = 4'd7;
    base = log_type.size();
    step();
    resp_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    d0 = done_total;
    step();
    @(negedge clk);
    check("t4_valid", 32'(sif.src_valid), 32'd0);
    check("t4_grant", 32'(grant), 32'd0);
    check("t4_eof", 32'(sif.eof_flag), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    rst = 1'b0; data_req = 1'b1; data_len = 4'd0;
    step();
    data_req = 1'b0;
    @(negedge clk);
    check("t4_new_grant", 32'(grant), 32'b001);
    check("t4_new_type", 32'(sif.packet_type), 32'd0);
    step();
    step();
    check("t4_done_count", 32'(done_total - d0), 32'd1);
    check_pkt("t4_pkt", base, 0, 1);

    // T5: requests change while a 6-beat data packet is in flight
    data_req = 1'b1; data_len = 4'd5; resp_len = 4'd0;
    base = log_type.size();
    step();
    data_req = 1'b0; data_len = 4'd0; resp_req = 1'b1;
    repeat (7) step();
    resp_req = 1'b0;
    repeat (3) step();
    check_pkt("t5_data", base, 0, 6);
    check_pkt("t5_resp", base + 1, 2, 1);

    // T6: long backpressure on a ctrl packet
    sif.src_ready = 1'b0; ctrl_req = 1'b1; ctrl_len = 4'd2;
    base = log_type.size();
    step();
    ctrl_req = 1'b0;
    p0 = pop_total;
    repeat (100) step();
    check("t6_pops_stalled", 32'(pop_total - p0), 32'd0);
    check("t6_valid_held", 32'(sif.src_valid), 32'd1);
    sif.src_ready = 1'b1;
    repeat (5) step();
    check_pkt("t6_pkt", base, 1, 3);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
